// File: rtl/spi_mnrch.sv
// 16-bit SPI monarch, mode 3 (CPOL=1/CPHA=1), full-duplex single-word transfers.
// SCLK is clk/32 with a 9-clk front porch and 15-clk back porch around SS_n.
module spi_mnrch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] resp,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } state_t;

    localparam logic [4:0] DIV_IDLE = 5'b10111;
    localparam logic [4:0] DIV_FALL = 5'b11111;
    localparam logic [4:0] DIV_RISE = 5'b01111;

    state_t      state_r;
    state_t      nxt_state_s;
    logic [4:0]  sclk_div_r;
    logic [15:0] shft_reg_r;
    logic [3:0]  bit_cnt_r;
    logic        miso_smpl_r;

    logic        ld_s;
    logic        cnt_s;
    logic        smpl_s;
    logic        shft_s;
    logic        fin_s;

    assign SCLK = sclk_div_r[4];
    assign resp = shft_reg_r;
    assign MOSI = shft_reg_r[15];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        nxt_state_s = state_r;
        ld_s        = 1'b0;
        cnt_s       = 1'b0;
        smpl_s      = 1'b0;
        shft_s      = 1'b0;
        fin_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (snd) begin
                    ld_s        = 1'b1;
                    nxt_state_s = FRONT;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            FRONT: begin
                // The first SCLK fall only launches the serf's MSB; no shift here.
                cnt_s = 1'b1;
                if (sclk_div_r == DIV_FALL) begin
                    nxt_state_s = SHIFT;
                end else begin
                    nxt_state_s = FRONT;
                end
            end
            SHIFT: begin
                cnt_s = 1'b1;
                if (sclk_div_r == DIV_RISE) begin
                    smpl_s = 1'b1;
                    if (bit_cnt_r == 4'd15) begin
                        nxt_state_s = BACK;
                    end else begin
                        nxt_state_s = SHIFT;
                    end
                end else if (sclk_div_r == DIV_FALL) begin
                    shft_s      = 1'b1;
                    nxt_state_s = SHIFT;
                end else begin
                    nxt_state_s = SHIFT;
                end
            end
            BACK: begin
                // Final shift happens without letting SCLK fall again.
                if (sclk_div_r == DIV_FALL) begin
                    shft_s      = 1'b1;
                    fin_s       = 1'b1;
                    nxt_state_s = IDLE;
                end else begin
                    cnt_s       = 1'b1;
                    nxt_state_s = BACK;
                end
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase
    end

    // SCLK divider and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_div_r <= DIV_IDLE;
            bit_cnt_r  <= 4'd0;
        end else begin
            if (fin_s) begin
                sclk_div_r <= DIV_IDLE;
            end else if (cnt_s) begin
                sclk_div_r <= sclk_div_r + 5'd1;
            end else begin
                sclk_div_r <= sclk_div_r;
            end
            if (ld_s) begin
                bit_cnt_r <= 4'd0;
            end else if (shft_s) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Shift register and MISO sample flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft_reg_r  <= 16'h0000;
            miso_smpl_r <= 1'b0;
        end else begin
            if (ld_s) begin
                shft_reg_r <= cmd;
            end else if (shft_s) begin
                shft_reg_r <= {shft_reg_r[14:0], miso_smpl_r};
            end else begin
                shft_reg_r <= shft_reg_r;
            end
            if (smpl_s) begin
                miso_smpl_r <= MISO;
            end else begin
                miso_smpl_r <= miso_smpl_r;
            end
        end
    end

    // Serf select and sticky completion flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n <= 1'b1;
            done <= 1'b0;
        end else begin
            if (ld_s) begin
                SS_n <= 1'b0;
                done <= 1'b0;
            end else if (fin_s) begin
                SS_n <= 1'b1;
                done <= 1'b1;
            end else begin
                SS_n <= SS_n;
                done <= done;
            end
        end
    end

endmodule
